// File: rtl/wb_vid_arbiter.sv
// Two-master Wishbone arbiter for the video frame-buffer bus: video reads have priority, CPU gets a bounded slot.
// Grant one edge after request; slave outputs and acks are combinational from state, so no added ack latency.
module wb_vid_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int VID_MAX_BEATS = 16,
    parameter int CPU_MAX_BEATS = 1
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst_n,
    input  logic            i_vid_cyc,
    input  logic [AW-1:0]   i_vid_addr,
    output logic            o_vid_ack,
    output logic [DW-1:0]   o_vid_dat,
    input  logic            i_cpu_cyc,
    input  logic            i_cpu_stb,
    input  logic            i_cpu_we,
    input  logic [AW-1:0]   i_cpu_addr,
    input  logic [DW-1:0]   i_cpu_dat,
    input  logic [DW/8-1:0] i_cpu_sel,
    output logic            o_cpu_ack,
    output logic [DW-1:0]   o_cpu_dat,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_dat,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_ack,
    input  logic [DW-1:0]   i_wb_dat,
    output logic [1:0]      o_grant
);

    localparam int MAXB = (VID_MAX_BEATS > CPU_MAX_BEATS) ? VID_MAX_BEATS : CPU_MAX_BEATS;
    localparam int CW   = $clog2(MAXB + 1);
    localparam logic [CW-1:0] VID_LIM = CW'(VID_MAX_BEATS);
    localparam logic [CW-1:0] CPU_LIM = CW'(CPU_MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_VID  = 2'b01,
        S_CPU  = 2'b10
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_cpu_first, w_cpu_first_nxt;

    assign o_vid_dat = i_wb_dat;
    assign o_cpu_dat = i_wb_dat;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cpu_first <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cpu_first <= w_cpu_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cpu_first_nxt = r_cpu_first;
        o_wb_cyc        = 1'b0;
        o_wb_stb        = 1'b0;
        o_wb_we         = 1'b0;
        o_wb_addr       = '0;
        o_wb_dat        = '0;
        o_wb_sel        = '0;
        o_vid_ack       = 1'b0;
        o_cpu_ack       = 1'b0;
        o_grant         = 2'b00;

        case (r_state)
            S_IDLE: begin
                // A late slave ack here is deliberately dropped: no owner.
                if (r_cpu_first && i_cpu_cyc) begin
                    w_state_nxt     = S_CPU;
                    w_cnt_nxt       = '0;
                    w_cpu_first_nxt = 1'b0;
                end else if (i_vid_cyc) begin
                    w_state_nxt = S_VID;
                    w_cnt_nxt   = '0;
                end else if (i_cpu_cyc) begin
                    w_state_nxt     = S_CPU;
                    w_cnt_nxt       = '0;
                    w_cpu_first_nxt = 1'b0;
                end
            end

            S_VID: begin
                o_grant   = 2'b01;
                o_wb_cyc  = i_vid_cyc;
                o_wb_stb  = i_vid_cyc;
                o_wb_addr = i_vid_addr;
                o_wb_sel  = '1;
                o_vid_ack = i_wb_ack & i_vid_cyc;
                if (!i_vid_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (o_vid_ack) begin
                    if (r_cnt < VID_LIM)
                        w_cnt_nxt = r_cnt + CW'(1);
                    // Saturated count means any later ack with the CPU waiting hands over.
                    if (i_cpu_cyc && (r_cnt >= VID_LIM - CW'(1))) begin
                        w_state_nxt     = S_IDLE;
                        w_cnt_nxt       = '0;
                        w_cpu_first_nxt = 1'b1;
                    end
                end
            end

            S_CPU: begin
                o_grant   = 2'b10;
                o_wb_cyc  = i_cpu_cyc;
                o_wb_stb  = i_cpu_stb;
                o_wb_we   = i_cpu_we;
                o_wb_addr = i_cpu_addr;
                o_wb_dat  = i_cpu_dat;
                o_wb_sel  = i_cpu_sel;
                o_cpu_ack = i_wb_ack & i_cpu_cyc & i_cpu_stb;
                if (!i_cpu_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (o_cpu_ack) begin
                    if (r_cnt < CPU_LIM)
                        w_cnt_nxt = r_cnt + CW'(1);
                    if (i_vid_cyc && (r_cnt >= CPU_LIM - CW'(1))) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_vid_arbiter.sv
// Bench for wb_vid_arbiter: ownership model checked every cycle plus directed handover scenarios.
module tb_wb_vid_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int VMAX = 16;
    localparam int CMAX = 1;
    localparam logic [AW-1:0] VBASE = 32'h0010_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n    = 1'b0;
    logic          vid_cyc  = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [DW-1:0] vid_dat;
    logic          cpu_cyc  = 1'b0;
    logic          cpu_stb  = 1'b0;
    logic          cpu_we   = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdat = '0;
    logic [SW-1:0] cpu_sel  = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdat;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdat;
    logic [SW-1:0] wb_sel;
    logic          wb_ack;
    logic [DW-1:0] wb_rdat  = '0;
    logic [1:0]    grant;
    logic          ack_auto  = 1'b0;
    logic          ack_force = 1'b0;

    // Slave: acks every strobed cycle when enabled, or a forced stray ack.
    assign wb_ack = (ack_auto & wb_stb) | ack_force;

    wb_vid_arbiter #(.AW(AW), .DW(DW), .VID_MAX_BEATS(VMAX), .CPU_MAX_BEATS(CMAX)) dut (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n),
        .i_vid_cyc(vid_cyc), .i_vid_addr(vid_addr), .o_vid_ack(vid_ack), .o_vid_dat(vid_dat),
        .i_cpu_cyc(cpu_cyc), .i_cpu_stb(cpu_stb), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_dat(cpu_wdat), .i_cpu_sel(cpu_sel), .o_cpu_ack(cpu_ack), .o_cpu_dat(cpu_rdat),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_dat(wb_wdat), .o_wb_sel(wb_sel), .i_wb_ack(wb_ack), .i_wb_dat(wb_rdat),
        .o_grant(grant)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Ownership model: who holds the bus, beats in this tenure, and the CPU-owed flag.
    int   m_own   = 0;
    int   m_beats = 0;
    bit   m_owed  = 1'b0;
    logic s_vid_cyc = 1'b0, s_cpu_cyc = 1'b0, s_cpu_stb = 1'b0, s_ack = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = 0; m_beats = 0; m_owed = 1'b0;
        end else if (m_own == 0) begin
            m_beats = 0;
            if (m_owed && s_cpu_cyc) begin m_own = 2; m_owed = 1'b0; end
            else if (s_vid_cyc)      m_own = 1;
            else if (s_cpu_cyc)      begin m_own = 2; m_owed = 1'b0; end
        end else if (m_own == 1) begin
            if (!s_vid_cyc) m_own = 0;
            else if (s_ack) begin
                m_beats++;
                if (m_beats >= VMAX && s_cpu_cyc) begin m_own = 0; m_owed = 1'b1; end
            end
        end else begin
            if (!s_cpu_cyc) m_own = 0;
            else if (s_ack && s_cpu_stb) begin
                m_beats++;
                if (m_beats >= CMAX && s_vid_cyc) m_own = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0]    e_grant;
        logic [2:0]    e_ctl;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdat;
        logic [SW-1:0] e_sel;
        logic          e_ack_in;
        logic [1:0]    e_acks;
        e_grant = 2'b00; e_ctl = 3'b000; e_addr = '0; e_wdat = '0; e_sel = '0; e_acks = 2'b00;
        if (m_own == 1) begin
            e_grant = 2'b01; e_ctl = {vid_cyc, vid_cyc, 1'b0}; e_addr = vid_addr; e_sel = '1;
        end else if (m_own == 2) begin
            e_grant = 2'b10; e_ctl = {cpu_cyc, cpu_stb, cpu_we}; e_addr = cpu_addr;
            e_wdat = cpu_wdat; e_sel = cpu_sel;
        end
        e_ack_in = (ack_auto & e_ctl[1]) | ack_force;
        if (m_own == 1) e_acks = {e_ack_in & vid_cyc, 1'b0};
        if (m_own == 2) e_acks = {1'b0, e_ack_in & cpu_cyc & cpu_stb};
        chk("m_grant", 128'(grant), 128'(e_grant));
        chk("m_ctl", 128'({wb_cyc, wb_stb, wb_we}), 128'(e_ctl));
        chk("m_addr", 128'(wb_addr), 128'(e_addr));
        chk("m_wdat_sel", 128'({wb_wdat, wb_sel}), 128'({e_wdat, e_sel}));
        chk("m_acks", 128'({vid_ack, cpu_ack}), 128'(e_acks));
        chk("m_rdat", 128'({vid_dat, cpu_rdat}), 128'({wb_rdat, wb_rdat}));
        s_vid_cyc = vid_cyc; s_cpu_cyc = cpu_cyc; s_cpu_stb = cpu_stb; s_ack = e_ack_in;
    end

    int vacks = 0;
    int dead  = 0;
    int gap   = 0;

    // Inputs change just after the rising edge; outputs are inspected on the falling edge.
    task automatic edge_();
        @(posedge clk); #1;
        wb_rdat  = $urandom;
        vid_addr = VBASE + 32'(vacks);
    endtask

    task automatic look();
        @(negedge clk);
        if (vid_ack) vacks++;
    endtask

    initial begin
        // Reset held with both masters requesting
        vid_cyc = 1'b1; cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_sel = 4'hF; cpu_addr = 32'h0000_4000;
        look(); look();
        chk("rst_wb_cyc", 128'(wb_cyc), 128'(1'b0));
        chk("rst_grant", 128'(grant), 128'(2'b00));
        chk("rst_acks_sel", 128'({vid_ack, cpu_ack, wb_sel}), 128'(0));
        edge_(); rst_n = 1'b1; look();
        chk("rel_idle", 128'(grant), 128'(2'b00));
        edge_(); look();
        chk("rel_vid_grant", 128'(grant), 128'(2'b01));
        edge_(); vid_cyc = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0; look();
        chk("vid_drop_same_cycle", 128'(wb_cyc), 128'(1'b0));
        edge_(); look();

        // Video alone, 40 back-to-back beats
        vacks = 0; gap = 0;
        edge_(); vid_cyc = 1'b1; ack_auto = 1'b1; look();
        for (int k = 0; k < 60 && vacks < 40; k++) begin
            edge_(); look();
            if (!vid_ack) gap++;
            if (vacks == 40) chk("vid40_last_addr", 128'(wb_addr), 128'(32'h0010_0027));
        end
        chk("vid40_beats", 128'(vacks), 128'(40));
        chk("vid40_no_gap", 128'(gap), 128'(0));
        edge_(); vid_cyc = 1'b0; ack_auto = 1'b0; look();
        edge_(); look();

        // CPU arrives at video beat 5; forced handover after beat 16
        vacks = 0; dead = 0;
        edge_(); vid_cyc = 1'b1; ack_auto = 1'b1; look();
        for (int k = 0; k < 80 && grant != 2'b10; k++) begin
            edge_();
            if (vacks == 5 && !cpu_cyc) begin
                cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1; cpu_sel = 4'b0011;
                cpu_wdat = 32'hA5A5_1234; cpu_addr = 32'h0000_0040;
            end
            look();
            if (grant == 2'b00) dead++;
        end
        chk("pre_cpu_grant", 128'(grant), 128'(2'b10));
        chk("pre_vid_beats", 128'(vacks), 128'(16));
        chk("pre_dead_cycles", 128'(dead), 128'(1));
        chk("cpu_wr_bus", 128'({wb_we, wb_sel, wb_wdat, wb_addr}),
            128'({1'b1, 4'b0011, 32'hA5A5_1234, 32'h0000_0040}));
        chk("cpu_wr_ack", 128'(cpu_ack), 128'(1'b1));
        edge_(); cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; look();
        chk("back_dead", 128'({grant, wb_cyc}), 128'(3'b000));
        edge_(); look();
        chk("vid_resume", 128'(grant), 128'(2'b01));
        edge_(); vid_cyc = 1'b0; ack_auto = 1'b0; look();
        edge_(); look();

        // Tie from IDLE: video first, then CPU after forced preemption
        vacks = 0;
        edge_(); vid_cyc = 1'b1; cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; look();
        edge_(); look();
        chk("tie_vid_wins", 128'(grant), 128'(2'b01));
        edge_(); ack_auto = 1'b1; look();
        for (int k = 0; k < 80 && grant != 2'b10; k++) begin
            edge_(); look();
        end
        chk("tie_cpu_first", 128'(grant), 128'(2'b10));
        chk("tie_vid_beats", 128'(vacks), 128'(16));
        edge_(); vid_cyc = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0; ack_auto = 1'b0; look();
        edge_(); look();

        // CPU abandons before ack; stray ack one cycle later
        edge_(); cpu_cyc = 1'b1; cpu_stb = 1'b1; look();
        edge_(); look();
        chk("abn_cpu_grant", 128'(grant), 128'(2'b10));
        edge_(); cpu_cyc = 1'b0; cpu_stb = 1'b0; look();
        chk("abn_cyc_drop", 128'(wb_cyc), 128'(1'b0));
        edge_(); ack_force = 1'b1; look();
        chk("abn_late_ack", 128'({grant, vid_ack, cpu_ack}), 128'(4'b0000));
        edge_(); ack_force = 1'b0; look();

        // Asynchronous reset in the middle of a CPU burst
        edge_(); cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1; cpu_wdat = 32'h1111_2222; ack_auto = 1'b1; look();
        edge_(); look();
        chk("burst_grant_ack", 128'({grant, cpu_ack}), 128'(3'b101));
        edge_(); look();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc_now", 128'({wb_cyc, grant}), 128'(3'b000));
        edge_(); vid_cyc = 1'b1; ack_auto = 1'b0; look();
        edge_(); rst_n = 1'b1; look();
        chk("arst_rel_idle", 128'(grant), 128'(2'b00));
        edge_(); look();
        chk("arst_tie_vid", 128'(grant), 128'(2'b01));
        edge_(); vid_cyc = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; look();
        edge_(); look();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_vid_arbiter.md
# wb_vid_arbiter

Two-master, one-slave arbiter for the shared video memory bus. It sits between the pixel stream fetcher (video master: reduced read-only Wishbone, `cyc`/`addr`/`ack`/`dat`) and the CPU data port (full classic Wishbone) on one side, and the frame-buffer memory slave on the other. Video has priority so the pixel FIFO never underruns. Bounded beat counters guarantee the CPU a slot while video is streaming.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)
- `VID_MAX_BEATS`, 16, max video acks per grant while the CPU is waiting (≥1)
- `CPU_MAX_BEATS`, 1, max CPU acks per grant while video is waiting (≥1)

Ports:
- `i_wb_clk` in 1: single clock; all logic on rising edge
- `i_wb_rst_n` in 1: reset, asynchronous, active-low
- `i_vid_cyc` in 1: video request; each ack moves one word
- `i_vid_addr` in AW: video word address
- `o_vid_ack` out 1: video ack
- `o_vid_dat` out DW: read data to video
- `i_cpu_cyc`, `i_cpu_stb`, `i_cpu_we` in 1 each: CPU bus cycle, strobe and write enable
- `i_cpu_addr` in AW; `i_cpu_dat` in DW; `i_cpu_sel` in DW/8
- `o_cpu_ack` out 1; `o_cpu_dat` out DW
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: to the slave
- `o_wb_addr` out AW; `o_wb_dat` out DW; `o_wb_sel` out DW/8
- `i_wb_ack` in 1; `i_wb_dat` in DW: from the slave
- `o_grant` out 2: 00 idle, 01 video, 10 CPU

## Operation
- FSM states: IDLE, VID, CPU. Also `cnt` (width `$clog2(max(VID_MAX_BEATS,CPU_MAX_BEATS)+1)`) and the flag `cpu_first`.
- **IDLE**
  - All slave outputs are 0; `o_grant`=00.
  - If `cpu_first` and `i_cpu_cyc` → CPU.
  - Else if `i_vid_cyc` → VID.
  - Else if `i_cpu_cyc` → CPU.
  - Entering any state clears `cnt`. Entering CPU clears `cpu_first`.
- **VID**
  - `o_wb_cyc`=`o_wb_stb`=`i_vid_cyc`, `o_wb_we`=0, `o_wb_sel`=all ones, `o_wb_addr`=`i_vid_addr`, `o_wb_dat`=0.
  - `o_vid_ack`=`i_wb_ack & i_vid_cyc`.
  - `cnt` increments on each `o_vid_ack`, saturating at `VID_MAX_BEATS`.
  - Exit to IDLE when `i_vid_cyc`=0.
  - Also exit to IDLE on the ack that makes `cnt`=`VID_MAX_BEATS` while `i_cpu_cyc`=1; this sets `cpu_first`.
  - If the CPU is idle, video keeps the bus indefinitely. The limit takes effect as soon as `cnt` ≥ `VID_MAX_BEATS` and `i_cpu_cyc` is sampled 1 on an ack.
- **CPU**
  - Slave outputs are direct copies of the `i_cpu_*` inputs.
  - `o_cpu_ack`=`i_wb_ack & i_cpu_cyc & i_cpu_stb`.
  - `cnt` increments on each `o_cpu_ack`.
  - Exit to IDLE when `i_cpu_cyc`=0.
  - Also exit to IDLE on the ack that makes `cnt`=`CPU_MAX_BEATS` while `i_vid_cyc`=1.
- Data paths:
  - `o_vid_dat`=`o_cpu_dat`=`i_wb_dat` unconditionally.
  - Acks go only to the current owner. The non-owner's ack is always 0.
- Master abandon: if the owner drops `cyc` mid-transfer, the arbiter returns to IDLE. A late `i_wb_ack` in IDLE is ignored; no master sees it.
- Simultaneous requests in IDLE: video wins unless `cpu_first`=1.
- Preempted master contract: the arbiter does not buffer requests. A master that keeps `cyc` high while not granted simply waits; it must tolerate `cyc`-held-without-ack.
- Reset values (asynchronous on `i_wb_rst_n`=0):
  - State IDLE, `cnt`=0, `cpu_first`=0.
  - Hence `o_wb_cyc`=`o_wb_stb`=`o_wb_we`=0, `o_wb_addr`=0, `o_wb_sel`=0, `o_vid_ack`=`o_cpu_ack`=0, `o_grant`=00.
  - Reset mid-transfer drops `o_wb_cyc` immediately, without waiting for a clock edge.

## Timing
- Grant latency: a request arriving in IDLE is granted at the next edge. `o_wb_cyc` rises 1 cycle after `i_*_cyc` rises.
- Slave outputs are combinational from the registered state and the owner's inputs. Acks are combinational from `i_wb_ack`, with zero added latency.
- On a limit-forced handover, the final ack cycle still shows the old owner's `cyc`. The next cycle is IDLE with `o_wb_cyc`=0, then the new owner is granted. This gives exactly one dead cycle between owners.
- On a handover caused by the owner dropping `cyc`, `o_wb_cyc` falls in the same cycle. The next edge goes to IDLE, and the next grant follows one edge later.
- Back-to-back acks from a pipelined slave are counted one per cycle.

## Test plan
- Reset: hold `i_wb_rst_n`=0 with both `cyc` high → all outputs 0, `o_grant`=00. Release → video granted 1 cycle later.
- Video only, slave acks every cycle, 40 beats → 40 `o_vid_ack`, `o_wb_addr` tracks `i_vid_addr`, no gap, `o_grant`=01 throughout.
- Video streaming, CPU raises `cyc` at video beat 5 (VID_MAX_BEATS=16) → `o_wb_cyc` low for 1 cycle after beat 16. CPU does 1 write (we=1, sel=4'b0011, data 0xA5A5_1234 reaches slave), then video resumes with 1 dead cycle.
- Both request on the same edge from IDLE with `cpu_first`=0 → video granted. Repeat right after a forced preemption → CPU granted.
- CPU owner drops `cyc` before ack, slave acks 1 cycle later → no `o_cpu_ack`/`o_vid_ack` pulse, FSM in IDLE.
- Assert reset during a CPU burst → `o_wb_cyc` falls asynchronously. After release, `cnt`=0 and `cpu_first`=0 (video wins tie).
